// File: rtl/shift_add_mult_ctrl_pkg.sv
// rtl/shift_add_mult_ctrl_pkg.sv - shared state encoding and default widths for the shift-add multiplier
package shift_add_mult_ctrl_pkg;

  // Default operand width and product / shift-register word width
  localparam int NSIZE_DEF = 8;
  localparam int MSIZE_DEF = 16;

  // Controller states; the encoding is fixed so other blocks can decode it
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_accum.sv
// rtl/shift_add_mult_ctrl_accum.sv - accumulator and right-shifting multiplier register
module sa_accum
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int Nsize = NSIZE_DEF,
  parameter int Msize = MSIZE_DEF
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             clear,
  input  logic             step,
  input  logic [Nsize-1:0] A,
  input  logic [Msize-1:0] Q_in,
  output logic [Msize-1:0] acc
);

  logic [Nsize-1:0] mreg;
  logic [Msize-1:0] acc_q;

  // acc is the running sum including the partial product of the current
  // step, so the controller can register the final product on the last edge
  assign acc = mreg[0] ? (acc_q + Q_in) : acc_q;

  // Capture the multiplier on clear; on each step fold in the partial product
  // and retire the consumed multiplier bit
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      mreg  <= '0;
      acc_q <= '0;
    end else if (clear) begin
      mreg  <= A;
      acc_q <= '0;
    end else if (step) begin
      acc_q <= acc;
      mreg  <= mreg >> 1;
    end
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - shift-and-add multiplier controller driving an external shift register
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int Nsize = NSIZE_DEF,
  parameter int Msize = MSIZE_DEF
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             Start,
  input  logic [Nsize-1:0] A,
  input  logic [Msize-1:0] Q_in,
  output logic             Ld,
  output logic             Sh,
  output logic             Di,
  output logic             Busy,
  output logic             Done,
  output logic [Msize-1:0] P
);

  localparam int CW = (Nsize > 1) ? $clog2(Nsize) : 1;
  localparam logic [CW-1:0] LAST = CW'(Nsize - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            step;
  logic [Msize-1:0] acc;

  // A new operation is only taken when idle or finishing; Start while busy is dropped
  assign accept = ((state == S_IDLE) || (state == S_DONE)) && Start;
  assign step   = (state == S_RUN);

  sa_accum #(
    .Nsize(Nsize),
    .Msize(Msize)
  ) u_accum (
    .Clk  (Clk),
    .Clr_n(Clr_n),
    .clear(accept),
    .step (step),
    .A    (A),
    .Q_in (Q_in),
    .acc  (acc)
  );

  // Controller FSM; outputs are registered from the next state so they are pure Moore
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      P     <= '0;
      Ld    <= 1'b0;
      Sh    <= 1'b0;
      Di    <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state <= S_LOAD;
            cnt   <= '0;
            Ld    <= 1'b1;
            Sh    <= 1'b0;
            Di    <= 1'b0;
            Busy  <= 1'b1;
            Done  <= 1'b0;
          end else begin
            state <= S_IDLE;
            Ld    <= 1'b0;
            Sh    <= 1'b0;
            Di    <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
          end
        end
        S_LOAD: begin
          state <= S_RUN;
          Ld    <= 1'b0;
          Sh    <= 1'b1;
          Di    <= 1'b1;
          Busy  <= 1'b1;
          Done  <= 1'b0;
        end
        S_RUN: begin
          if (cnt == LAST) begin
            state <= S_DONE;
            P     <= acc;
            Ld    <= 1'b0;
            Sh    <= 1'b0;
            Di    <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          Ld    <= 1'b0;
          Sh    <= 1'b0;
          Di    <= 1'b0;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - directed self-checking bench for the shift-add multiplier controller
module tb_shift_add_mult_ctrl;

  localparam int NS = 8;
  localparam int MS = 16;

  logic          Clk;
  logic          Clr_n;
  logic          Start;
  logic [NS-1:0] A;
  logic [MS-1:0] Q_in;
  logic          Ld, Sh, Di, Busy, Done;
  logic [MS-1:0] P;

  logic [NS-1:0] Bop;
  logic [MS-1:0] sr_q;
  logic          sr_clr;

  int vec_n;
  int miscompares;

  typedef struct {
    logic [NS-1:0] a;
    logic [NS-1:0] b;
    logic [MS-1:0] p;
  } vec_t;

  vec_t vecs[7];

  shift_add_mult_ctrl #(
    .Nsize(NS),
    .Msize(MS)
  ) dut (
    .Clk  (Clk),
    .Clr_n(Clr_n),
    .Start(Start),
    .A    (A),
    .Q_in (Q_in),
    .Ld   (Ld),
    .Sh   (Sh),
    .Di   (Di),
    .Busy (Busy),
    .Done (Done),
    .P    (P)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model of the existing shift register: active-high clear from inverted Clr_n
  assign sr_clr = ~Clr_n;
  assign Q_in   = sr_q;
  always_ff @(posedge Clk or posedge sr_clr) begin
    if (sr_clr) sr_q <= '0;
    else if (Ld) sr_q <= MS'(Bop);
    else if (Sh && Di) sr_q <= {sr_q[MS-2:0], 1'b0};
    else if (Sh) sr_q <= {1'b0, sr_q[MS-1:1]};
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one operation with a one-cycle Start pulse and count strobe cycles
  task automatic run_op(input int idx, input logic [NS-1:0] a, input logic [NS-1:0] b,
                        input logic [MS-1:0] exp_p);
    int busy_n, ld_n, sh_n, done_n, done_cycle;
    busy_n = 0; ld_n = 0; sh_n = 0; done_n = 0; done_cycle = -1;
    @(negedge Clk);
    A = a; Bop = b; Start = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge Clk); #1;
      if (e == 0) Start = 1'b0;
      if (Busy) busy_n++;
      if (Ld)   ld_n++;
      if (Sh)   sh_n++;
      if (Done) begin
        done_n++;
        if (done_cycle < 0) done_cycle = e + 1;
      end
    end
    check($sformatf("v%0d P", idx), 32'(P), 32'(exp_p));
    check($sformatf("v%0d done_cycle", idx), 32'(done_cycle), 32'd10);
    check($sformatf("v%0d done_len", idx), 32'(done_n), 32'd1);
    check($sformatf("v%0d busy_len", idx), 32'(busy_n), 32'd9);
    check($sformatf("v%0d ld_len", idx), 32'(ld_n), 32'd1);
    check($sformatf("v%0d sh_len", idx), 32'(sh_n), 32'd8);
  endtask

  initial begin
    vec_n = 0;
    miscompares = 0;
    vecs[0] = '{a: 8'd3,   b: 8'd5,   p: 16'h000F};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'h0000};
    vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'h0000};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'h0001};
    vecs[5] = '{a: 8'd128, b: 8'd2,   p: 16'h0100};
    vecs[6] = '{a: 8'd170, b: 8'd85,  p: 16'h3872};

    Clr_n = 1'b0; Start = 1'b0; A = '0; Bop = '0;
    #1;
    check("rst P",    32'(P),    32'd0);
    check("rst Busy", 32'(Busy), 32'd0);
    check("rst Done", 32'(Done), 32'd0);
    check("rst Ld",   32'(Ld),   32'd0);
    check("rst Sh",   32'(Sh),   32'd0);
    check("rst Di",   32'(Di),   32'd0);
    @(negedge Clk); @(negedge Clk);
    Clr_n = 1'b1;
    @(posedge Clk); #1;
    check("idle Busy", 32'(Busy), 32'd0);

    for (int i = 0; i < 7; i++) run_op(i, vecs[i].a, vecs[i].b, vecs[i].p);

    // Start held through the whole run with A wandering; back-to-back from DONE
    for (int e = 0; e <= 20; e++) begin
      @(negedge Clk);
      if (e == 0) begin A = 8'd7; Bop = 8'd9; Start = 1'b1; end
      else if (e <= 9) A = 8'(8'h30 + e);
      else if (e == 10) begin A = 8'd4; Bop = 8'd11; end
      else Start = 1'b0;
      @(posedge Clk); #1;
      if (e == 5) check("hold busy", 32'(Busy), 32'd1);
      if (e == 9) begin
        check("hold done1", 32'(Done), 32'd1);
        check("hold P1",    32'(P),    32'd63);
      end
      if (e == 10) begin
        check("b2b busy",  32'(Busy), 32'd1);
        check("b2b ld",    32'(Ld),   32'd1);
        check("b2b done0", 32'(Done), 32'd0);
        check("b2b Pheld", 32'(P),    32'd63);
      end
      if (e == 18) begin
        check("b2b Pheld2", 32'(P),    32'd63);
        check("b2b early",  32'(Done), 32'd0);
      end
      if (e == 19) begin
        check("b2b done2", 32'(Done), 32'd1);
        check("b2b P2",    32'(P),    32'd44);
      end
    end

    // Reset asserted in the fourth RUN cycle of 15*15
    @(negedge Clk);
    A = 8'd15; Bop = 8'd15; Start = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(posedge Clk); #1;
      if (e == 0) Start = 1'b0;
    end
    check("midrun busy", 32'(Busy), 32'd1);
    #2;
    Clr_n = 1'b0;
    #1;
    check("clr P",    32'(P),    32'd0);
    check("clr Busy", 32'(Busy), 32'd0);
    check("clr Done", 32'(Done), 32'd0);
    check("clr Sh",   32'(Sh),   32'd0);
    check("clr Di",   32'(Di),   32'd0);
    @(negedge Clk);
    Clr_n = 1'b1;
    run_op(7, 8'd2, 8'd3, 16'h0006);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 Parameter Nsize, default 8: multiplier and multiplicand operand width.
REQ-002 Parameter Msize, default 16: width of the shift-register word and of the product; Msize >= 2*Nsize for exact products.
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Clr_n  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  request to begin a multiply.
REQ-006 A  input  Nsize  multiplier operand, sampled on the edge that accepts Start.
REQ-007 Q_in  input  Msize  shifted multiplicand from the downstream-driven shift register.
REQ-008 Ld  output  1  shift-register load strobe.
REQ-009 Sh  output  1  shift-register shift enable.
REQ-010 Di  output  1  shift direction to the shift register; 1 = left shift.
REQ-011 Busy  output  1  high while a multiply is in progress.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 P  output  Msize  registered product, held until the next completion.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-015 IDLE/DONE + Start=1 -> LOAD; the edge SHALL capture A into the multiplier register, clear the accumulator and clear the bit counter.
REQ-016 IDLE + Start=0 -> IDLE; DONE + Start=0 -> IDLE.
REQ-017 LOAD SHALL last exactly one cycle with Ld=1 and Sh=0, then go to RUN; the shift register loads the multiplicand (B) on that edge.
REQ-018 RUN SHALL last exactly Nsize cycles, tracked by a counter 0..Nsize-1, with Sh=1 and Di=1 in every RUN cycle.
REQ-019 In each RUN edge, when multiplier bit 0 is 1 the accumulator SHALL add Q_in modulo 2^Msize; the multiplier register SHALL then shift right by one with 0 fill.
REQ-020 On the last RUN edge (counter = Nsize-1), P SHALL take the final accumulator value and the state SHALL go to DONE.
REQ-021 Done SHALL be 1 only in DONE. Busy SHALL be 1 only in LOAD or RUN. Ld and Sh SHALL be 0 in IDLE and DONE. All outputs SHALL be Moore outputs.
REQ-022 Latency: with Start accepted at edge 0, Done SHALL be high between edge Nsize+1 and edge Nsize+2, and P SHALL be valid from edge Nsize+1.
REQ-023 Start while Busy=1 SHALL be ignored, with no effect on the operands or the count.
REQ-024 Start in DONE SHALL begin a new operation (back-to-back); P SHALL keep the previous product until the next completion.
REQ-025 A=0 or B=0 SHALL still take the full Nsize+2 latency and give P=0; there is no early termination.
REQ-026 When Msize < 2*Nsize, the product SHALL be truncated modulo 2^Msize with no error flag.

Reset
REQ-027 Clr_n=0 SHALL at once force IDLE, and SHALL clear P, the accumulator, the multiplier register and the counter to 0, and Ld, Sh, Di, Busy and Done to 0, in any state including mid-RUN.
REQ-028 After Clr_n deasserts, the first Start SHALL be accepted no earlier than the first rising Clk edge.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3) and the default Nsize/Msize values.
REQ-030 The FSM and counter SHALL live in shift_add_mult_ctrl; the accumulator and multiplier register SHALL be one sub-module, sa_accum (ports: Clk, Clr_n, clear, step, A, Q_in, acc).
REQ-031 The integration level SHALL connect Ld/Sh/Di/Q_in to the existing shift register; its active-high clear SHALL be driven from the inverted Clr_n.

Verification
REQ-032 The bench SHALL model the shift register (Ld loads B zero-extended; Sh with Di=1 shifts left, 0 fill) and SHALL run with Nsize=8, Msize=16.
REQ-033 A=3, B=5, Start pulse -> Done high exactly at cycle 10 after the accept edge; P=16'h000F.
REQ-034 A=255, B=255 -> P=16'hFE01; Busy high for 9 cycles; Ld high for 1 cycle; Sh high for 8 cycles.
REQ-035 A=0, B=200 -> P=0; Done still at cycle 10.
REQ-036 Start held high from the accept edge through RUN with A changing each cycle -> only the first A is used (A=7, B=9 -> P=63); a second operation starts from DONE back-to-back with P=63 held until its Done.
REQ-037 Clr_n pulsed low in RUN cycle 4 of A=15, B=15 -> P=0, Busy=0, Done=0 at once; a fresh A=2, B=3 afterward -> P=6.
